// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and frame constants for the IMEM boot loader
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CNT_LO = 3'd1,
        CNT_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } boot_state_e;

    localparam logic [7:0] BOOT_MAGIC     = 8'hA5;
    localparam int         CNT_W          = 16;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         LANE_W         = 2;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream in and IMEM write port out of the boot loader
interface imem_boot_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Host side: supplies bytes, observes IMEM writes
    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    // Loader side
    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// rtl/imem_boot_loader_byte_packer.sv - little-endian 4-byte to word assembler
module imem_boot_loader_byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        last_lane_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              word_valid_q, word_valid_d;
    logic [31:0]       word_q, word_d;

    // Bytes shift in from the top so the first byte ends up in [7:0]
    always_comb begin
        lane_d       = lane_q;
        shreg_d      = shreg_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        if (clear_i) begin
            lane_d = '0;
        end else if (byte_valid_i) begin
            shreg_d = {byte_i, shreg_q[31:8]};
            lane_d  = lane_q + LANE_W'(1);
            if (lane_q == LAST_LANE) begin
                word_valid_d = 1'b1;
                word_d       = {byte_i, shreg_q[31:8]};
            end
        end
    end

    // Lane counter, shift register and registered word output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q       <= '0;
            shreg_q      <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            lane_q       <= lane_d;
            shreg_q      <= shreg_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
        end
    end

    assign last_lane_o  = (lane_q == LAST_LANE);
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte stream to IMEM loader holding the core in reset
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] MAGIC  = BOOT_MAGIC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    imem_boot_loader_if.slave bus,
    output logic              cpu_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam logic [CNT_W:0]  MAX_WORDS = (CNT_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] WORD_ONE  = (ADDR_W+1)'(1);

    boot_state_e       state_q, state_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_q, cpu_d;

    logic              rx_ready;
    logic              fire;
    logic              pk_clear, pk_valid, pk_last, pk_word_valid;
    logic [31:0]       pk_word;
    logic [CNT_W-1:0]  new_count;

    // The stream stalls only once the core is running
    assign rx_ready  = (state_q != DONE);
    assign fire      = bus.rx_valid & rx_ready;
    assign new_count = {bus.rx_data, cnt_lo_q};

    // Frame parser: next state, running checksum, word counter and status flags
    always_comb begin
        state_d  = state_q;
        csum_d   = csum_q;
        cnt_lo_d = cnt_lo_q;
        count_d  = count_q;
        words_d  = words_q;
        addr_d   = addr_q;
        done_d   = done_q;
        err_d    = err_q;
        cpu_d    = cpu_q;
        pk_clear = 1'b0;
        pk_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire && bus.rx_data == MAGIC) begin
                    state_d  = CNT_LO;
                    csum_d   = '0;
                    count_d  = '0;
                    words_d  = '0;
                    pk_clear = 1'b1;
                end
            end
            CNT_LO: begin
                if (fire) begin
                    cnt_lo_d = bus.rx_data;
                    csum_d   = csum_q ^ bus.rx_data;
                    state_d  = CNT_HI;
                end
            end
            CNT_HI: begin
                if (fire) begin
                    count_d = new_count;
                    csum_d  = csum_q ^ bus.rx_data;
                    if ({1'b0, new_count} > MAX_WORDS) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else if (new_count == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    csum_d   = csum_q ^ bus.rx_data;
                    pk_valid = 1'b1;
                    if (pk_last) begin
                        addr_d  = words_q[ADDR_W-1:0];
                        words_d = words_q + WORD_ONE;
                        if ((CNT_W+1)'(words_q) + (CNT_W+1)'(1) == {1'b0, count_q}) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (fire) begin
                    if (bus.rx_data == csum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        cpu_d   = 1'b1;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
            DONE, ERROR: begin
                if (restart) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    cpu_d   = 1'b0;
                    words_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            csum_q   <= '0;
            cnt_lo_q <= '0;
            count_q  <= '0;
            words_q  <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cpu_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            csum_q   <= csum_d;
            cnt_lo_q <= cnt_lo_d;
            count_q  <= count_d;
            words_q  <= words_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cpu_q    <= cpu_d;
        end
    end

    imem_boot_loader_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_i       (bus.rx_data),
        .last_lane_o  (pk_last),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    assign bus.rx_ready   = rx_ready;
    assign bus.imem_we    = pk_word_valid;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = pk_word;
    assign cpu_rst_n      = cpu_q;
    assign load_done      = done_q;
    assign load_err       = err_q;
    assign words_loaded   = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for the IMEM boot loader
module tb_imem_boot_loader;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic        cpu_rst_n, load_done, load_err;
    logic [10:0] words_loaded;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_accept_cyc = -1;
    wr_t exp_q[$];

    imem_boot_loader_if #(.ADDR_W(10)) bus ();

    imem_boot_loader #(.ADDR_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .bus          (bus.slave),
        .cpu_rst_n    (cpu_rst_n),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every IMEM write must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
                chk("wr_data", bus.imem_wdata, e.data);
                chk("wr_latency", 32'(cyc), 32'(last_accept_cyc));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int tries;
        tries = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (bus.rx_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_ready_timeout: got %0b expected 1", bus.rx_ready);
            bus.rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            last_accept_cyc = cyc;
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic expect_wr(input logic [9:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_status(input string tag, input logic done, input logic err,
                              input logic cpu, input logic rdy, input logic [10:0] words);
        chk({tag, "_load_done"}, 32'(load_done), 32'(done));
        chk({tag, "_load_err"}, 32'(load_err), 32'(err));
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(cpu));
        chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'(rdy));
        chk({tag, "_words"}, 32'(words_loaded), 32'(words));
    endtask

    initial begin
        logic [7:0] good[$];
        logic [7:0] bad[$];
        logic [7:0] csum;
        int drain;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        bad = good;
        bad[11] = 8'h00;

        repeat (3) @(negedge clk);
        chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b1, 11'd0);
        chk("reset_we", 32'(bus.imem_we), 32'd0);
        rst_n = 1'b1;

        // 1) good two-word frame
        expect_wr(10'd0, 32'h00000013);
        expect_wr(10'd1, 32'h00100093);
        send_frame(good);
        settle();
        chk_status("t1", 1'b1, 1'b0, 1'b1, 1'b0, 11'd2);
        pulse_restart();
        chk_status("t1_restart", 1'b0, 1'b0, 1'b0, 1'b1, 11'd0);

        // 2) checksum mismatch: words still written, then ERROR
        expect_wr(10'd0, 32'h00000013);
        expect_wr(10'd1, 32'h00100093);
        send_frame(bad);
        settle();
        chk_status("t2", 1'b0, 1'b1, 1'b0, 1'b1, 11'd2);
        send_byte(8'hA5);
        settle();
        chk("t2_err_sticky", 32'(load_err), 32'd1);
        pulse_restart();

        // 3) junk before MAGIC is dropped
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        expect_wr(10'd0, 32'h00000013);
        expect_wr(10'd1, 32'h00100093);
        send_frame(good);
        settle();
        chk_status("t3", 1'b1, 1'b0, 1'b1, 1'b0, 11'd2);
        pulse_restart();

        // 4) empty frame
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00});
        settle();
        chk_status("t4", 1'b1, 1'b0, 1'b1, 1'b0, 11'd0);
        pulse_restart();

        // 5) count 0x0401 overflows a 1024-word IMEM; later bytes are dropped
        send_frame('{8'hA5, 8'h01, 8'h04});
        @(negedge clk);
        chk("t5_err_immediate", 32'(load_err), 32'd1);
        send_frame('{8'h13, 8'h00, 8'h00, 8'h00});
        settle();
        chk_status("t5", 1'b0, 1'b1, 1'b0, 1'b1, 11'd0);
        pulse_restart();

        // Boundary: exactly 1024 words, word i = i
        csum = 8'h00 ^ 8'h04;
        send_frame('{8'hA5, 8'h00, 8'h04});
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] w;
            w = 32'(i);
            expect_wr(10'(i), w);
            send_frame('{w[7:0], w[15:8], w[23:16], w[31:24]});
            csum = csum ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        send_byte(csum);
        settle();
        chk_status("full", 1'b1, 1'b0, 1'b1, 1'b0, 11'd1024);
        pulse_restart();

        // 6) async reset after 5 data bytes, then a clean frame
        expect_wr(10'd0, 32'h00000013);
        send_frame('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_status("t6_rst", 1'b0, 1'b0, 1'b0, 1'b1, 11'd0);
        chk("t6_rst_we", 32'(bus.imem_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_wr(10'd0, 32'h00000013);
        expect_wr(10'd1, 32'h00100093);
        send_frame(good);
        settle();
        chk_status("t6_a", 1'b1, 1'b0, 1'b1, 1'b0, 11'd2);
        pulse_restart();
        chk("t6_restart_cpu", 32'(cpu_rst_n), 32'd0);

        // Second frame; a restart pulse mid-frame is ignored
        expect_wr(10'd0, 32'hDEADBEEF);
        send_frame('{8'hA5, 8'h01, 8'h00});
        pulse_restart();
        send_frame('{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23});
        settle();
        chk_status("t6_b", 1'b1, 1'b0, 1'b1, 1'b0, 11'd1);

        drain = 0;
        while (exp_q.size() != 0 && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
